image_buffer_pixel_reader: RTL
==============================

# image_buffer_pixel_reader

Streams a stored 800x600 grayscale frame back out of ZBT SRAM as an 8-bit pixel stream for the feature-detection pipeline. It is the read-side counterpart of the image buffer writer. It attaches to the SRAM arbiter's spare R1 read port: it issues word addresses and accepts 32-bit read data. It unpacks four pixels per word and presents them on a ready/valid pixel interface. Frame runs are bracketed by start/done handshakes of the same style as the writer's.

## Interface
Parameters:
- N_PIXEL, 480000, pixels per frame; must be a multiple of 4; N_WORDS = N_PIXEL/4.
- BUF1_BASE, 131072, word address of buffer 1; buffer 0 starts at word 0.
- FIFO_DEPTH, 4, read-data FIFO depth in words; this is also the cap on outstanding reads.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- start  in  1  request to begin a frame; level, held by requester until start_ack.
- frame_sel  in  1  buffer select, sampled when start is accepted.
- start_ack  out  1  one-cycle pulse acknowledging start.
- done  out  1  frame complete; held until done_ack.
- done_ack  in  1  clears done.
- addr  out  18  SRAM word address to arbiter R1.
- addr_valid  out  1  addr is valid.
- addr_ready  in  1  arbiter accepts addr.
- data  in  32  read data from arbiter R1.
- data_valid  in  1  data is valid.
- data_ready  out  1  reader can accept data.
- pixel  out  8  output pixel.
- pixel_valid  out  1  pixel is valid.
- pixel_ready  in  1  downstream accepts pixel.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start=1. On that transition: latch base (frame_sel ? BUF1_BASE : 0), clear all counters, pulse start_ack.
  - RUN → DONE on the handshake of pixel N_PIXEL-1.
  - DONE → IDLE on the first cycle with done=1 and done_ack=1.
  - start is ignored in RUN and DONE.
- Address issue, RUN only:
  - Gate: addr_valid = (words_issued < N_WORDS) and (outstanding + fifo_count < FIFO_DEPTH).
  - addr = base + words_issued.
  - words_issued and outstanding increment on an addr handshake.
  - Once asserted, addr_valid and addr stay stable until accepted; credits never shrink while an address waits.
- Data return:
  - data_ready is high whenever the FIFO is not full. The credit scheme guarantees no overflow.
  - A data handshake pushes the word into the FIFO and decrements outstanding.
  - data_valid with outstanding=0 is a protocol violation: the word is dropped and counters do not underflow.
- Unpacker:
  - Holds one word plus byte index 0..3.
  - Pixel order within a word is data[31:24], [23:16], [15:8], [7:0].
  - On a pixel handshake at index 3, the next FIFO word loads in the same cycle if present, so there is no bubble.
  - pixel_valid=0 when no word is held.
  - pixel and pixel_valid stay stable while pixel_valid=1 and pixel_ready=0.
- Widths: words_issued is 17 bits. Address add is 18 bits; BUF1_BASE + N_WORDS ≤ 2^18 is required, so no wrap. The pixel counter is 19 bits.

## Timing
- Reset values: start_ack=0, done=0, addr=0, addr_valid=0, data_ready=0, pixel=0, pixel_valid=0. FSM returns to IDLE; FIFO and counters are cleared.
- Reset mid-frame aborts immediately. Data arriving after reset deasserts is ignored until the next start.
- start_ack is high the cycle after start is first sampled in IDLE. The first addr_valid is high the cycle after start_ack.
- Each word pushes into the FIFO on its handshake. The first pixel_valid is no later than 2 cycles after the first data handshake.
- Throughput: 1 pixel/cycle sustained when pixel_ready=1 and the arbiter returns ≥1 word per 4 cycles.
- done rises the cycle after the last pixel handshake.
  - A done_ack already held high yields a 1-cycle done pulse.
  - A new start may be accepted the cycle after DONE exits.

## Test plan
- Zero-latency arbiter, pixel_ready=1, N_PIXEL=16, frame_sel=0, words 0x00010203 + 0x04040404·k:
  - addresses 0..3 in order;
  - pixels 0x00..0x0F back-to-back with no gaps;
  - done the cycle after the 16th pixel.
- frame_sel=1 → first addr = 131072, last addr = 131072 + N_WORDS - 1.
- Arbiter with 10-cycle read latency and addr_ready always 1 → never more than 4 outstanding reads plus FIFO words; data_ready never low while data_valid is high; pixel order unchanged.
- Random pixel_ready (50%) → pixel held stable across stalls; exactly N_PIXEL handshakes; no duplicated or dropped bytes.
- reset=0 asserted mid-frame after 7 pixels, then restart → all outputs at reset values immediately; restarted frame begins at the base address with pixel 0.
- start held high through a frame and done_ack held high → one start_ack per frame; done pulses for exactly 1 cycle; the next frame starts the cycle after IDLE is re-entered.

Source files
------------

// File: rtl/image_buffer_pixel_reader.sv
// Streams a stored frame out of SRAM as 8-bit pixels: issues word reads under a
// credit limit, buffers returned words in a small FIFO and unpacks them MSB-first.
module image_buffer_pixel_reader #(
    parameter int N_PIXEL    = 480000,
    parameter int BUF1_BASE  = 131072,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        frame_sel,
    output logic        start_ack,
    output logic        done,
    input  logic        done_ack,
    output logic [17:0] addr,
    output logic        addr_valid,
    input  logic        addr_ready,
    input  logic [31:0] data,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [7:0]  pixel,
    output logic        pixel_valid,
    input  logic        pixel_ready
);
    localparam int N_WORDS = N_PIXEL / 4;
    localparam int CW      = $clog2(FIFO_DEPTH + 1);
    localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [16:0]   WORDS_W  = 17'(N_WORDS);
    localparam logic [18:0]   LAST_PIX = 19'(N_PIXEL - 1);
    localparam logic [17:0]   BUF1_W   = 18'(BUF1_BASE);
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;

    logic [17:0]   base_q, base_d, addr_q, addr_d;
    logic [16:0]   words_q, words_d;
    logic [CW-1:0] outst_q, outst_d, fcnt_q, fcnt_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [31:0]   word_q, word_d;
    logic          held_q, held_d;
    logic [1:0]    idx_q, idx_d;
    logic [18:0]   pcnt_q, pcnt_d;
    logic          start_ack_q, start_ack_d, addr_valid_q, addr_valid_d;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic          start_go, addr_hs, push, pop, pix_hs;
    logic [CW:0]   credit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (pix_hs && pcnt_q == LAST_PIX) state_d = DONE;
            DONE:    if (done_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_ack   = start_ack_q;
        done        = (state_q == DONE);
        addr        = addr_q;
        addr_valid  = addr_valid_q;
        data_ready  = (state_q == RUN) && (fcnt_q != DEPTH_C);
        pixel_valid = held_q;
        pixel       = '0;
        if (held_q) begin
            case (idx_q)
                2'd0:    pixel = word_q[31:24];
                2'd1:    pixel = word_q[23:16];
                2'd2:    pixel = word_q[15:8];
                default: pixel = word_q[7:0];
            endcase
        end
    end

    always_comb begin
        start_go = (state_q == IDLE) && start;
        addr_hs  = addr_valid_q && addr_ready;
        // A word with no read in flight is a protocol violation and is dropped.
        push     = data_valid && data_ready && (outst_q != '0);
        pix_hs   = held_q && pixel_ready;
        // Reload on the last byte's handshake so the stream has no bubble.
        pop      = (fcnt_q != '0) && (!held_q || (pix_hs && idx_q == 2'd3));

        base_d      = base_q;
        words_d     = words_q + 17'(addr_hs);
        outst_d     = outst_q + CW'(addr_hs) - CW'(push);
        fcnt_d      = fcnt_q + CW'(push) - CW'(pop);
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        word_d      = word_q;
        held_d      = held_q;
        idx_d       = idx_q;
        pcnt_d      = pcnt_q + 19'(pix_hs);
        start_ack_d = start_go;

        if (push) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        if (pop)  rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;

        if (pop) begin
            word_d = fifo_mem[rptr_q];
            held_d = 1'b1;
            idx_d  = 2'd0;
        end else if (pix_hs) begin
            held_d = (idx_q != 2'd3);
            idx_d  = idx_q + 2'd1;
        end

        if (start_go) begin
            base_d  = frame_sel ? BUF1_W : '0;
            words_d = '0;
            outst_d = '0;
            fcnt_d  = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            held_d  = 1'b0;
            idx_d   = 2'd0;
            pcnt_d  = '0;
        end

        // Credits are judged on post-edge counts, so a waiting address never oversubscribes.
        credit = {1'b0, outst_d} + {1'b0, fcnt_d};
        if (addr_valid_q && !addr_ready) begin
            addr_valid_d = 1'b1;
            addr_d       = addr_q;
        end else begin
            addr_valid_d = (state_q == RUN) && (words_d < WORDS_W) && (credit < DEPTH_W);
            addr_d       = base_q + {1'b0, words_d};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            base_q       <= '0;
            addr_q       <= '0;
            words_q      <= '0;
            outst_q      <= '0;
            fcnt_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            word_q       <= '0;
            held_q       <= 1'b0;
            idx_q        <= 2'd0;
            pcnt_q       <= '0;
            start_ack_q  <= 1'b0;
            addr_valid_q <= 1'b0;
        end else begin
            base_q       <= base_d;
            addr_q       <= addr_d;
            words_q      <= words_d;
            outst_q      <= outst_d;
            fcnt_q       <= fcnt_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            word_q       <= word_d;
            held_q       <= held_d;
            idx_q        <= idx_d;
            pcnt_q       <= pcnt_d;
            start_ack_q  <= start_ack_d;
            addr_valid_q <= addr_valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wptr_q] <= data;
    end
endmodule
